// File: rtl/simon_pkg.sv
// simon_pkg: shared colour, length and playback-state definitions for the Simon Says blocks
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_RED    = 2'd0;
    localparam colour_t COL_GREEN  = 2'd1;
    localparam colour_t COL_BLUE   = 2'd2;
    localparam colour_t COL_YELLOW = 2'd3;

    localparam int MAX_SEQ_LEN = 15;

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} play_state_t;

    function automatic logic [3:0] colour_onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/sequence_player_phase_timer.sv
// phase_timer: tick counter that pulses done on the tick reaching the terminal count
module phase_timer #(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [TICK_W-1:0] term,
    output logic              done
);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    // terminal tick and clear both return the count to zero
    always_comb begin
        done  = en && !clr && (cnt_q + TICK_W'(1) == term);
        cnt_d = (clr || done) ? '0 : (en ? cnt_q + TICK_W'(1) : cnt_q);
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sequence_player.sv
// sequence_player: shows a latched packed colour sequence on the LEDs with timed ON and OFF phases
module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int TICK_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic [31:0] sequence_val,
    input  logic [3:0]  sequence_len,
    output logic [1:0]  colour_val,
    output logic [3:0]  led,
    output logic        busy,
    output logic        complete_play
);

    play_state_t       state_q, state_d;
    logic [31:0]       seq_q, seq_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        index_q, index_d;
    colour_t           colour_val_q, colour_val_d;
    logic [3:0]        led_q, led_d;
    logic              busy_q, busy_d;
    logic              complete_q, complete_d;
    colour_t           elem_d;
    logic              phase_done;
    logic              timer_clr;
    logic [TICK_W-1:0] term;

    assign timer_clr = !(state_q == ON || state_q == OFF);
    assign term      = (state_q == ON) ? TICK_W'(ON_TICKS) : TICK_W'(OFF_TICKS);

    phase_timer #(.TICK_W(TICK_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (tick),
        .term (term),
        .done (phase_done)
    );

    // next state; LED/busy follow the next state so the first colour shows one cycle after start
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        len_d   = len_q;
        index_d = index_q;
        case (state_q)
            IDLE: if (start) begin
                seq_d   = sequence_val;
                len_d   = sequence_len;
                index_d = '0;
                state_d = (sequence_len == 4'd0) ? DONE : ON;
            end
            ON:   if (phase_done) state_d = OFF;
            OFF:  if (phase_done) begin
                if ({1'b0, index_q} + 5'd1 == {1'b0, len_q}) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ON;
                end
            end
            default: ;
        endcase
        elem_d       = seq_d[{index_d, 1'b0} +: 2];
        colour_val_d = (state_d == ON) ? elem_d : COL_RED;
        led_d        = (state_d == ON) ? colour_onehot(elem_d) : 4'b0000;
        busy_d       = (state_d == ON) || (state_d == OFF);
        complete_d   = (state_q == DONE);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            len_q        <= '0;
            index_q      <= '0;
            colour_val_q <= COL_RED;
            led_q        <= '0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
            index_q      <= index_d;
            colour_val_q <= colour_val_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            complete_q   <= complete_d;
        end
    end

    assign colour_val    = colour_val_q;
    assign led           = led_q;
    assign busy          = busy_q;
    assign complete_play = complete_q;

endmodule
